// File: rtl/sb_tx_framer_pkg.sv
// sb_tx_framer_pkg: shared sideband TX types and framing constants.
package sb_tx_framer_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} sb_state_e;
  localparam int SB_PKT_UI = 64;
  localparam int SB_GAP_UI = 32;
  typedef logic [63:0] sb_word_t;
endpackage

// File: rtl/sb_tx_framer.sv
// sb_tx_framer: frames header/data words for the sideband serializer with enable,
// pack-finished and clock-enable timing plus the inter-word idle gap.
module sb_tx_framer
  import sb_tx_framer_pkg::*;
#(
  parameter int PKT_UI = SB_PKT_UI,
  parameter int GAP_UI = SB_GAP_UI
) (
  input  logic        i_pll_clk,
  input  logic        i_rst_n,
  input  logic        i_pkt_valid,
  input  logic [63:0] i_pkt_header,
  input  logic [63:0] i_pkt_data,
  input  logic        i_pkt_has_data,
  output logic        o_pkt_ready,
  output logic [63:0] o_ser_data,
  output logic        o_ser_enable,
  output logic        o_ser_pack_finished,
  output logic        o_last_pack,
  output logic        o_sb_clk_en,
  output logic        o_busy
);
  localparam int BW = $clog2(PKT_UI);
  localparam int GW = $clog2(GAP_UI);
  localparam logic [BW-1:0] LAST_BIT = BW'(PKT_UI - 1);
  localparam logic [GW-1:0] LAST_GAP = GW'(GAP_UI - 1);
  sb_state_e state, nxt;
  logic [BW-1:0] bit_cnt;
  logic [GW-1:0] gap_cnt;
  sb_word_t hdr, dat;
  logic has_data, word_sel, clk_en;
  logic accept, bit_done, gap_done;
  assign accept   = state == IDLE && i_pkt_valid;
  assign bit_done = state == SHIFT && bit_cnt == LAST_BIT;
  assign gap_done = state == GAP && gap_cnt == LAST_GAP;
  // Holding registers only change on accept, so the mux stays stable between LOADs.
  assign o_ser_data          = word_sel ? dat : hdr;
  assign o_ser_enable        = state == LOAD || state == SHIFT;
  assign o_ser_pack_finished = bit_done;
  assign o_last_pack         = state != IDLE && (word_sel || !has_data);
  assign o_pkt_ready         = state == IDLE;
  assign o_busy              = state != IDLE;
  assign o_sb_clk_en         = clk_en;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = i_pkt_valid ? LOAD : IDLE;
      LOAD:    nxt = SHIFT;
      SHIFT:   nxt = bit_done ? GAP : SHIFT;
      GAP:     nxt = gap_done ? ((!word_sel && has_data) ? LOAD : IDLE) : GAP;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge i_pll_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      hdr      <= '0;
      dat      <= '0;
      has_data <= 1'b0;
      word_sel <= 1'b0;
      clk_en   <= 1'b0;
    end else begin
      state   <= nxt;
      // Registered one cycle behind enable so the gate covers serial bits T1..T64.
      clk_en  <= state == LOAD || state == SHIFT;
      bit_cnt <= state == LOAD ? BW'(1) : (state == SHIFT && !bit_done) ? bit_cnt + 1'b1 : bit_cnt;
      gap_cnt <= state == SHIFT ? '0 : state == GAP ? gap_cnt + 1'b1 : gap_cnt;
      if (accept) begin
        hdr      <= i_pkt_header;
        dat      <= i_pkt_data;
        has_data <= i_pkt_has_data;
        word_sel <= 1'b0;
      end else if (gap_done && !word_sel && has_data) begin
        word_sel <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sb_tx_framer.sv
// tb_sb_tx_framer: directed bench for sb_tx_framer with a behavioural serializer model.
module tb_sb_tx_framer;
  logic        i_pll_clk;
  logic        i_rst_n;
  logic        i_pkt_valid;
  logic [63:0] i_pkt_header;
  logic [63:0] i_pkt_data;
  logic        i_pkt_has_data;
  logic        o_pkt_ready;
  logic [63:0] o_ser_data;
  logic        o_ser_enable;
  logic        o_ser_pack_finished;
  logic        o_last_pack;
  logic        o_sb_clk_en;
  logic        o_busy;
  int n_checks = 0;
  int n_err = 0;

  sb_tx_framer dut (
    .i_pll_clk(i_pll_clk),
    .i_rst_n(i_rst_n),
    .i_pkt_valid(i_pkt_valid),
    .i_pkt_header(i_pkt_header),
    .i_pkt_data(i_pkt_data),
    .i_pkt_has_data(i_pkt_has_data),
    .o_pkt_ready(o_pkt_ready),
    .o_ser_data(o_ser_data),
    .o_ser_enable(o_ser_enable),
    .o_ser_pack_finished(o_ser_pack_finished),
    .o_last_pack(o_last_pack),
    .o_sb_clk_en(o_sb_clk_en),
    .o_busy(o_busy)
  );

  initial i_pll_clk = 1'b0;
  always #5 i_pll_clk = ~i_pll_clk;

  // Serializer model: loads on enable from idle, drives bit 63 first, bit 0 after pack_finished.
  logic [63:0] sh;
  logic        txd, sbusy;
  int          scnt;
  always @(posedge i_pll_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sh <= '0; txd <= 1'b0; sbusy <= 1'b0; scnt <= 0;
    end else if (!sbusy) begin
      if (o_ser_enable) begin
        sh <= o_ser_data; txd <= o_ser_data[63]; scnt <= 1; sbusy <= 1'b1;
      end
    end else begin
      txd  <= sh[63-scnt];
      scnt <= scnt + 1;
      if (o_ser_pack_finished) sbusy <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_data"}, 128'(o_ser_data), 128'h0);
    check({tag, "_ctl"}, 128'({o_ser_enable, o_ser_pack_finished, o_last_pack, o_sb_clk_en, o_busy, o_pkt_ready}), 128'b000001);
  endtask

  // Sends one packet starting at a negedge; cycle i=1 is T0 of the first word (A+1).
  task automatic run_pkt(input logic [63:0] h, input logic [63:0] d, input logic hd,
                         input bit hold, input bit toggle, input int abort_at);
    int i = 0, en = 0, pf = 0, pf_at = 0, l1 = 0, l2 = 0, ce = 0, gap_low = 0, gap_en = 0, rdy_low = 0, chg = 0;
    logic lp1 = 1'b0, lp2 = 1'b0, prev_en = 1'b0;
    logic [63:0] sd1 = '0, sd2 = '0, prev;
    logic [127:0] rx = '0;
    bit aborted = 0;
    i_pkt_header = h; i_pkt_data = d; i_pkt_has_data = hd; i_pkt_valid = 1'b1;
    prev = o_ser_data;
    do begin
      @(negedge i_pll_clk);
      i++;
      if (toggle) begin
        i_pkt_valid = 1'(i % 2); i_pkt_header = h ^ 64'(i); i_pkt_data = ~d;
      end else if (!hold) i_pkt_valid = 1'b0;
      if (o_ser_enable && !prev_en) begin
        if (l1 == 0) begin l1 = i; sd1 = o_ser_data; lp1 = o_last_pack; end
        else begin l2 = i; sd2 = o_ser_data; lp2 = o_last_pack; end
      end
      prev_en = o_ser_enable;
      if (o_ser_pack_finished) begin pf++; if (pf_at == 0) pf_at = i; end
      if (o_ser_enable) en++;
      if (o_ser_enable && i >= 65 && i <= 96) gap_en++;
      if (o_sb_clk_en) begin ce++; rx = {rx[126:0], txd}; end
      if (!o_sb_clk_en && i >= 66 && i <= 97) gap_low++;
      if (!o_pkt_ready) rdy_low++;
      if (i != l1 && i != l2 && o_ser_data !== prev) chg++;
      prev = o_ser_data;
      if (i == abort_at) begin
        i_rst_n = 1'b0;
        #1;
        check_idle_outputs("reset_mid");
        aborted = 1;
      end
    end while (!aborted && !o_pkt_ready && i < 400);
    if (toggle || !hold) i_pkt_valid = 1'b0;
    if (!aborted) begin
      check("cycles_to_ready", 128'(i), hd ? 128'd193 : 128'd97);
      check("ready_low", 128'(rdy_low), hd ? 128'd192 : 128'd96);
      check("enable_cycles", 128'(en), hd ? 128'd128 : 128'd64);
      check("pf_count", 128'(pf), hd ? 128'd2 : 128'd1);
      check("pf_at_t63", 128'(pf_at), 128'd64);
      check("load1_at", 128'(l1), 128'd1);
      check("load1_data", 128'(sd1), 128'(h));
      check("load1_last", 128'(lp1), 128'(!hd));
      check("gap_enable", 128'(gap_en), 128'd0);
      check("clk_en_cycles", 128'(ce), hd ? 128'd128 : 128'd64);
      check("serial_stream", rx, hd ? {h, d} : {64'h0, h});
      check("ser_data_stable", 128'(chg), 128'd0);
      if (hd) begin
        check("load2_at", 128'(l2), 128'd97);
        check("load2_data", 128'(sd2), 128'(d));
        check("load2_last", 128'(lp2), 128'd1);
        check("clk_en_gap", 128'(gap_low), 128'd32);
      end
    end
  endtask

  initial begin
    i_rst_n = 1'b0; i_pkt_valid = 1'b0; i_pkt_header = '0; i_pkt_data = '0; i_pkt_has_data = 1'b0;
    #1;
    check_idle_outputs("reset");
    @(negedge i_pll_clk);
    @(negedge i_pll_clk);
    i_rst_n = 1'b1;
    @(negedge i_pll_clk);
    run_pkt(64'hA5A5_0000_FFFF_1234, 64'hDEAD_BEEF_0000_0001, 1'b0, 0, 0, 0);
    @(negedge i_pll_clk);
    run_pkt(64'h1, 64'h8000_0000_0000_0001, 1'b1, 0, 0, 0);
    run_pkt(64'h1111_2222_3333_4444, 64'h0, 1'b0, 1, 0, 0);
    run_pkt(64'h5555_6666_7777_8888, 64'h0, 1'b0, 1, 0, 0);
    run_pkt(64'h9999_AAAA_BBBB_CCCC, 64'h0, 1'b0, 1, 0, 0);
    i_pkt_valid = 1'b0;
    @(negedge i_pll_clk);
    run_pkt(64'hF0F0_1234_5678_0F0F, 64'h0, 1'b0, 0, 1, 0);
    @(negedge i_pll_clk);
    run_pkt(64'hCAFE_F00D_0000_0000, 64'h0123_4567_89AB_CDEF, 1'b1, 0, 0, 137);
    @(negedge i_pll_clk);
    i_rst_n = 1'b1;
    #1;
    check("ready_after_release", 128'(o_pkt_ready), 128'd1);
    run_pkt(64'h0F1E_2D3C_4B5A_6978, 64'h8765_4321_0FED_CBA9, 1'b1, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
